// File: rtl/step_sequence_monitor.sv
// Half-step stepper coil monitor: synchronizes the ULN2003 drive lines, debounces
// the coil pattern and tracks legal phase transitions into a saturating position.
module step_sequence_monitor #(
    parameter int STABLE_CYCLES = 1000,
    parameter int POS_WIDTH     = 16,
    parameter int LIMIT_HI      = 2000,
    parameter int LIMIT_LO      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  coil_in,
    input  logic                        zero_pos,
    input  logic                        clr_fault,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir,
    output logic                        step_pulse,
    output logic [2:0]                  phase,
    output logic                        phase_valid,
    output logic                        at_limit_hi,
    output logic                        at_limit_lo,
    output logic                        fault,
    output logic [1:0]                  fault_code
);
    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
    localparam logic signed [POS_WIDTH-1:0] LIM_HI  = POS_WIDTH'(LIMIT_HI);
    localparam logic signed [POS_WIDTH-1:0] LIM_LO  = POS_WIDTH'(LIMIT_LO);
    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_SKIP    = 2'b10;

    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    logic [3:0]                  r_sync1, r_sync2, r_pat;
    logic [CW-1:0]               r_cnt;
    state_t                      r_state;
    logic signed [POS_WIDTH-1:0] r_position;
    logic                        r_dir, r_step, r_pv, r_at_hi, r_at_lo, r_fault;
    logic [2:0]                  r_phase;
    logic [1:0]                  r_code;

    logic       w_accept, w_idle, w_illegal, w_at_max, w_at_min;
    logic [2:0] w_idx, w_delta;

    // Returns {illegal, idle, phase index}
    function automatic logic [4:0] f_decode(input logic [3:0] pat);
        case (pat)
            4'b1000: return 5'b00_000;
            4'b1100: return 5'b00_001;
            4'b0100: return 5'b00_010;
            4'b0110: return 5'b00_011;
            4'b0010: return 5'b00_100;
            4'b0011: return 5'b00_101;
            4'b0001: return 5'b00_110;
            4'b1001: return 5'b00_111;
            4'b0000: return 5'b01_000;
            default: return 5'b10_000;
        endcase
    endfunction

    assign {w_illegal, w_idle, w_idx} = f_decode(r_pat);
    assign w_accept = (r_cnt == CW'(STABLE_CYCLES));
    assign w_delta  = w_idx - r_phase;
    assign w_at_max = (r_position == POS_MAX);
    assign w_at_min = (r_position == POS_MIN);

    // The counter parks at STABLE_CYCLES+1 after acceptance so a pattern fires once
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
            r_pat   <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= coil_in;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_pat) begin
                r_pat <= r_sync2;
                r_cnt <= CW'(1);
            end else if (r_cnt <= CW'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SYNC;
            r_position <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_phase    <= 3'd0;
            r_pv       <= 1'b0;
            r_fault    <= 1'b0;
            r_code     <= FC_NONE;
            r_at_hi    <= (LIMIT_HI <= 0);
            r_at_lo    <= (LIMIT_LO >= 0);
        end else begin
            r_step  <= 1'b0;
            r_at_hi <= (r_position >= LIM_HI);
            r_at_lo <= (r_position <= LIM_LO);
            case (r_state)
                SYNC: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                            r_code  <= FC_ILLEGAL;
                        end else if (!w_idle) begin
                            r_phase <= w_idx;
                            r_pv    <= 1'b1;
                            r_state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (w_accept && w_illegal) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                        r_code  <= FC_ILLEGAL;
                        r_pv    <= 1'b0;
                    end else if (w_accept && !w_idle) begin
                        // Phase tracking continues at saturation; only the count stops
                        case (w_delta)
                            3'd0: ;
                            3'd1: begin
                                r_phase <= w_idx;
                                if (!w_at_max) begin
                                    r_position <= r_position + POS_WIDTH'(1);
                                    r_dir      <= 1'b1;
                                    r_step     <= 1'b1;
                                end
                            end
                            3'd7: begin
                                r_phase <= w_idx;
                                if (!w_at_min) begin
                                    r_position <= r_position - POS_WIDTH'(1);
                                    r_dir      <= 1'b0;
                                    r_step     <= 1'b1;
                                end
                            end
                            default: begin
                                r_state <= FAULT;
                                r_fault <= 1'b1;
                                r_code  <= FC_SKIP;
                                r_pv    <= 1'b0;
                            end
                        endcase
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        r_state <= SYNC;
                        r_fault <= 1'b0;
                        r_code  <= FC_NONE;
                    end
                end
                default: r_state <= SYNC;
            endcase
            if (zero_pos) r_position <= '0;
        end
    end

    assign position    = r_position;
    assign dir         = r_dir;
    assign step_pulse  = r_step;
    assign phase       = r_phase;
    assign phase_valid = r_pv;
    assign at_limit_hi = r_at_hi;
    assign at_limit_lo = r_at_lo;
    assign fault       = r_fault;
    assign fault_code  = r_code;

endmodule

// File: doc/step_sequence_monitor.md
STEP_SEQUENCE_MONITOR -- requirements
Module: step_sequence_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: consecutive cycles a synchronized coil pattern must hold before acceptance (20 us at 50 MHz).
REQ-002 SHALL have parameter POS_WIDTH, default 16: width of the signed position counter.
REQ-003 SHALL have parameter LIMIT_HI, default 2000, and LIMIT_LO, default 0: soft travel limits in half-steps, signed.
REQ-004 SHALL have ports, in this order:
- clk  in  1  50 MHz system clock.
- rst  in  1  reset; one clock; synchronous, active-high.
- coil_in  in  4  observed ULN2003 drive lines, bit3..bit0 = IN4..IN1; asynchronous to clk.
- zero_pos  in  1  one-cycle pulse; loads position to 0.
- clr_fault  in  1  one-cycle pulse; clears a latched fault.
- position  out  POS_WIDTH  signed half-step count.
- dir  out  1  direction of last counted step: 1 = forward, 0 = reverse.
- step_pulse  out  1  one-cycle pulse per counted step.
- phase  out  3  last accepted legal phase index.
- phase_valid  out  1  phase holds a tracked reference.
- at_limit_hi  out  1  position >= LIMIT_HI.
- at_limit_lo  out  1  position <= LIMIT_LO.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 illegal pattern, 10 skipped step.

Function
REQ-005 SHALL pass coil_in through a two-flop synchronizer before any decode.
REQ-006 SHALL decode half-step phases: 1000=0, 1100=1, 0100=2, 0110=3, 0010=4, 0011=5, 0001=6, 1001=7; 0000 = idle (legal, no phase); the other seven codes = illegal.
REQ-007 SHALL restart the stability counter on every change of the synchronized pattern.
REQ-008 SHALL accept a pattern exactly once, when it has been stable STABLE_CYCLES cycles.
REQ-009 SHALL make the accepted-pattern effect visible on the outputs at clock edge STABLE_CYCLES+3, counting the first edge that samples the new coil_in as edge 1.
REQ-010 SHALL implement FSM states SYNC, TRACK and FAULT; reset state SYNC.
REQ-011 In SYNC, an accepted legal phase SHALL load phase, set phase_valid=1 and go to TRACK with no step counted.
- Accepted idle: stay in SYNC.
- Accepted illegal: go to FAULT with code 01.
REQ-012 In TRACK, for an accepted legal phase, delta=(new-phase) mod 8:
- delta 1: position+1, dir=1, step_pulse.
- delta 7: position-1, dir=0, step_pulse.
- delta 0: no action.
- delta 2..6: FAULT with code 10, no count.
REQ-013 In TRACK, accepted idle SHALL leave phase and position unchanged, so a resumed step counts against the last phase.
REQ-014 In TRACK, accepted illegal SHALL go to FAULT with code 01.
REQ-015 In FAULT, fault=1, phase_valid=0, no counting, fault_code held; only the first fault code is recorded.
REQ-016 clr_fault in FAULT SHALL go to SYNC next cycle with fault=0 and fault_code=00; clr_fault is ignored in other states.
REQ-017 position SHALL saturate at the signed POS_WIDTH max/min: no wrap, no step_pulse at saturation.
REQ-018 zero_pos SHALL set position=0 next cycle in any state; coincident with a step, zero wins and step_pulse still asserts.
REQ-019 at_limit_hi and at_limit_lo SHALL be registered compares of position, one cycle after position updates.

Reset
REQ-020 rst SHALL, on the next edge:
- Set position=0, dir=0, step_pulse=0, phase=0, phase_valid=0, fault=0, fault_code=00.
- Clear the synchronizer and stability counter to pattern 0000.
- Set state=SYNC.
- Give at_limit_lo=1 and at_limit_hi=0 with default limits.
REQ-021 rst asserted mid-acceptance SHALL discard the pending pattern with no step counted.

Verification (STABLE_CYCLES=4)
REQ-022 After reset, apply 1000 then 1100, each held 20 cycles: position=1, dir=1, one step_pulse at edge 7 after the 1100 change.
REQ-023 Apply 1000,1001,0001,0011 (20 cycles each): position=-3, dir=0, three step_pulses.
REQ-024 Apply a 2-cycle glitch 0100 within a held 1000 in TRACK: no acceptance, position unchanged, no fault.
REQ-025 In TRACK at phase 0, apply 0110: fault=1, code 10, position held. Then pulse clr_fault: state SYNC, fault=0.
REQ-026 Apply 1111: fault code 01. Apply zero_pos coincident with a counted step: position=0 and step_pulse=1.
REQ-027 With LIMIT_HI=3, take 3 forward steps: at_limit_hi=1 one cycle after position=3. Assert rst mid-acceptance: all outputs at reset values.
